// File: rtl/data_memory_pkg.sv
// Shared constants and decode helpers for the memory-mapped data memory.
// Word addressing, STAT register layout and the read-source selector live here.
package data_memory_pkg;

  localparam int BYTE_W   = 8;
  localparam int STAT_NEW = 0;
  localparam int STAT_OVR = 1;

  typedef enum logic {
    SRC_ARRAY = 1'b0,
    SRC_AUX   = 1'b1
  } rd_src_e;

  function automatic int byte_lanes(input int data_w);
    return data_w / BYTE_W;
  endfunction

  function automatic logic [31:0] word_index(input logic [31:0] addr);
    return {2'b00, addr[31:2]};
  endfunction

  // The STAT register at 4*depth is the last legal address.
  function automatic logic addr_valid(input logic [31:0] addr, input int depth);
    return (addr[1:0] == 2'b00) && (addr <= (32'd4 * 32'(depth)));
  endfunction

endpackage

// File: rtl/data_memory_mmio_if.sv
// Core load/store bus, peripheral handshake and display taps of the data memory.
interface data_memory_mmio_if #(
  parameter int DATA_W = 32
);

  logic [31:0]         Address;
  logic [DATA_W-1:0]   WriteData;
  logic [DATA_W/8-1:0] ByteEnable;
  logic                WriteEnable;
  logic                ReadEnable;
  logic [DATA_W-1:0]   ReadData;
  logic                ReadValid;
  logic                AddrError;
  logic [DATA_W-1:0]   MouseData;
  logic                MouseValid;
  logic                MouseReady;
  logic [DATA_W-1:0]   DATO1;
  logic [DATA_W-1:0]   DATO2;
  logic [DATA_W-1:0]   RESULTADO;

  modport master (
    output Address, WriteData, ByteEnable, WriteEnable, ReadEnable,
    output MouseData, MouseValid,
    input  ReadData, ReadValid, AddrError, MouseReady,
    input  DATO1, DATO2, RESULTADO
  );

  modport slave (
    input  Address, WriteData, ByteEnable, WriteEnable, ReadEnable,
    input  MouseData, MouseValid,
    output ReadData, ReadValid, AddrError, MouseReady,
    output DATO1, DATO2, RESULTADO
  );

endinterface

// File: rtl/dm_word_array.sv
// DEPTH x DATA_W word storage: byte-lane CPU write, full-word peripheral write,
// registered read port and combinational tap reads.
module dm_word_array
  import data_memory_pkg::*;
#(
  parameter  int DATA_W       = 32,
  parameter  int DEPTH        = 16,
  parameter  int IN_SLOT      = 1,
  parameter  int TAP0_SLOT    = 4,
  parameter  int IN_RST_VAL   = 2,
  parameter  int TAP0_RST_VAL = 2,
  parameter  int N_TAPS       = 3,
  localparam int IDX_W        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LANES        = byte_lanes(DATA_W)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           wr_en_i,
  input  logic [IDX_W-1:0]               wr_idx_i,
  input  logic [LANES-1:0]               wr_be_i,
  input  logic [DATA_W-1:0]              wr_data_i,
  input  logic                           pw_en_i,
  input  logic [DATA_W-1:0]              pw_data_i,
  input  logic                           rd_en_i,
  input  logic [IDX_W-1:0]               rd_idx_i,
  output logic [DATA_W-1:0]              rd_data_o,
  input  logic [N_TAPS-1:0][IDX_W-1:0]   tap_idx_i,
  output logic [N_TAPS-1:0][DATA_W-1:0]  tap_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // IN_SLOT takes precedence if it shares a slot with TAP0_SLOT.
  function automatic logic [DATA_W-1:0] rst_word(input int i);
    if (i == IN_SLOT) begin
      return DATA_W'(IN_RST_VAL);
    end else if (i == TAP0_SLOT) begin
      return DATA_W'(TAP0_RST_VAL);
    end else begin
      return '0;
    end
  endfunction

  // Next array contents: peripheral word first, CPU lanes on top.
  always_comb begin
    mem_d = mem_q;
    mem_d[IN_SLOT] = pw_en_i ? pw_data_i : mem_q[IN_SLOT];
    for (int k = 0; k < LANES; k++) begin
      mem_d[wr_idx_i][BYTE_W*k +: BYTE_W] = (wr_en_i && wr_be_i[k])
          ? wr_data_i[BYTE_W*k +: BYTE_W]
          : mem_d[wr_idx_i][BYTE_W*k +: BYTE_W];
    end
  end

  // Storage and read register; reads see pre-edge contents.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= rst_word(i);
      end
      rd_data_q <= '0;
    end else begin
      mem_q <= mem_d;
      if (rd_en_i) begin
        rd_data_q <= mem_q[rd_idx_i];
      end else begin
        rd_data_q <= rd_data_q;
      end
    end
  end

  // Display taps follow the array directly.
  always_comb begin
    tap_data_o = '0;
    for (int t = 0; t < N_TAPS; t++) begin
      tap_data_o[t] = mem_q[tap_idx_i[t]];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/data_memory_mmio.sv
// Data memory with a memory-mapped peripheral input slot, sticky NEW/OVR status
// at 4*DEPTH, address checking and three continuous display taps.
module data_memory_mmio
  import data_memory_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 16,
  parameter int IN_SLOT      = 1,
  parameter int TAP0_SLOT    = 4,
  parameter int TAP1_SLOT    = 5,
  parameter int TAP2_SLOT    = 7,
  parameter int IN_RST_VAL   = 2,
  parameter int TAP0_RST_VAL = 2
) (
  input logic              CLK,
  input logic              RST,
  data_memory_mmio_if.slave bus
);

  localparam int          IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          LANES     = byte_lanes(DATA_W);
  localparam logic [31:0] STAT_ADDR = 32'd4 * 32'(DEPTH);
  localparam logic [31:0] IN_ADDR   = 32'd4 * 32'(IN_SLOT);

  logic                          ok_s;
  logic                          stat_s;
  logic                          wr_arr_s;
  logic                          rd_arr_s;
  logic                          stat_rd_s;
  logic                          mready_s;
  logic                          xfer_s;
  logic [IDX_W-1:0]              idx_s;
  logic [DATA_W-1:0]             stat_word_s;
  logic [DATA_W-1:0]             arr_rd_s;
  logic [2:0][IDX_W-1:0]         tap_idx_s;
  logic [2:0][DATA_W-1:0]        tap_data_s;

  logic                          new_q, new_d;
  logic                          ovr_q, ovr_d;
  rd_src_e                       src_q, src_d;
  logic [DATA_W-1:0]             aux_q, aux_d;
  logic                          valid_q;
  logic                          err_q;

  // Address decode and peripheral handshake.
  always_comb begin
    ok_s        = addr_valid(bus.Address, DEPTH);
    stat_s      = (bus.Address == STAT_ADDR);
    idx_s       = IDX_W'(word_index(bus.Address));
    wr_arr_s    = bus.WriteEnable && ok_s && !stat_s;
    rd_arr_s    = bus.ReadEnable && ok_s && !stat_s;
    stat_rd_s   = bus.ReadEnable && stat_s;
    mready_s    = !(bus.WriteEnable && (bus.Address == IN_ADDR));
    xfer_s      = bus.MouseValid && mready_s;
    stat_word_s = '0;
    stat_word_s[STAT_NEW] = new_q;
    stat_word_s[STAT_OVR] = ovr_q;
  end

  // Sticky status; a transfer on the clearing edge leaves NEW set and OVR clear.
  always_comb begin
    new_d = new_q;
    ovr_d = ovr_q;
    if (xfer_s) begin
      new_d = 1'b1;
      ovr_d = stat_rd_s ? 1'b0 : (ovr_q | new_q);
    end else if (stat_rd_s) begin
      new_d = 1'b0;
      ovr_d = 1'b0;
    end else begin
      new_d = new_q;
      ovr_d = ovr_q;
    end
  end

  // Read-data source: array word, STAT snapshot, or zero for a bad read.
  always_comb begin
    src_d = src_q;
    aux_d = aux_q;
    if (rd_arr_s) begin
      src_d = SRC_ARRAY;
    end else if (stat_rd_s) begin
      src_d = SRC_AUX;
      aux_d = stat_word_s;
    end else if (bus.ReadEnable) begin
      src_d = SRC_AUX;
      aux_d = '0;
    end else begin
      src_d = src_q;
      aux_d = aux_q;
    end
  end

  // Control/status registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      new_q   <= 1'b0;
      ovr_q   <= 1'b0;
      src_q   <= SRC_AUX;
      aux_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      new_q   <= new_d;
      ovr_q   <= ovr_d;
      src_q   <= src_d;
      aux_q   <= aux_d;
      valid_q <= bus.ReadEnable;
      err_q   <= (bus.WriteEnable || bus.ReadEnable) && !ok_s;
    end
  end

  assign tap_idx_s[0] = IDX_W'(TAP0_SLOT);
  assign tap_idx_s[1] = IDX_W'(TAP1_SLOT);
  assign tap_idx_s[2] = IDX_W'(TAP2_SLOT);

  dm_word_array #(
    .DATA_W       (DATA_W),
    .DEPTH        (DEPTH),
    .IN_SLOT      (IN_SLOT),
    .TAP0_SLOT    (TAP0_SLOT),
    .IN_RST_VAL   (IN_RST_VAL),
    .TAP0_RST_VAL (TAP0_RST_VAL),
    .N_TAPS       (3)
  ) u_array (
    .clk_i      (CLK),
    .rst_i      (RST),
    .wr_en_i    (wr_arr_s),
    .wr_idx_i   (idx_s),
    .wr_be_i    (bus.ByteEnable[LANES-1:0]),
    .wr_data_i  (bus.WriteData),
    .pw_en_i    (xfer_s),
    .pw_data_i  (bus.MouseData),
    .rd_en_i    (rd_arr_s),
    .rd_idx_i   (idx_s),
    .rd_data_o  (arr_rd_s),
    .tap_idx_i  (tap_idx_s),
    .tap_data_o (tap_data_s)
  );

  assign bus.ReadData   = (src_q == SRC_ARRAY) ? arr_rd_s : aux_q;
  assign bus.ReadValid  = valid_q;
  assign bus.AddrError  = err_q;
  assign bus.MouseReady = mready_s;
  assign bus.DATO1      = tap_data_s[0];
  assign bus.DATO2      = tap_data_s[1];
  assign bus.RESULTADO  = tap_data_s[2];

endmodule

// File: tb/tb_data_memory_mmio.sv
// Directed bench for data_memory_mmio with hand-computed expectations.
module tb_data_memory_mmio;

  localparam int DW = 32;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  data_memory_mmio_if #(.DATA_W(DW)) bus ();

  data_memory_mmio #(
    .DATA_W(DW), .DEPTH(16), .IN_SLOT(1), .TAP0_SLOT(4), .TAP1_SLOT(5),
    .TAP2_SLOT(7), .IN_RST_VAL(2), .TAP0_RST_VAL(2)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.WriteEnable = 1'b0;
    bus.ReadEnable  = 1'b0;
    bus.MouseValid  = 1'b0;
    bus.ByteEnable  = 4'h0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.Address     = a;
    bus.WriteData   = d;
    bus.ByteEnable  = be;
    bus.WriteEnable = 1'b1;
    step();
    idle();
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus.Address    = a;
    bus.ReadEnable = 1'b1;
    step();
    check({tag, ".valid"}, 32'(bus.ReadValid), 32'd1);
    check({tag, ".data"}, bus.ReadData, exp);
    idle();
    step();
    check({tag, ".pulse"}, 32'(bus.ReadValid), 32'd0);
  endtask

  task automatic xfer(input logic [31:0] d);
    bus.MouseData  = d;
    bus.MouseValid = 1'b1;
    step();
    bus.MouseValid = 1'b0;
  endtask

  initial begin
    idle();
    bus.Address   = 32'h0;
    bus.WriteData = 32'h0;
    bus.MouseData = 32'h0;

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    check("rst.rdata", bus.ReadData, 32'h0);
    check("rst.rvalid", 32'(bus.ReadValid), 32'd0);
    check("rst.aerr", 32'(bus.AddrError), 32'd0);
    check("rst.dato1", bus.DATO1, 32'h2);
    check("rst.dato2", bus.DATO2, 32'h0);
    check("rst.result", bus.RESULTADO, 32'h0);
    RST = 1'b0;
    step();
    check("rst.mready", 32'(bus.MouseReady), 32'd1);
    rd("rst.w1", 32'h04, 32'h2);
    rd("rst.w4", 32'h10, 32'h2);
    rd("rst.w0", 32'h00, 32'h0);
    rd("rst.stat", 32'h40, 32'h0);

    // Byte-lane writes
    wr(32'h10, 32'h11223344, 4'hF);
    wr(32'h10, 32'hAABBCCDD, 4'b0101);
    check("be.dato1", bus.DATO1, 32'h11BB33DD);
    rd("be.w4", 32'h10, 32'h11BB33DD);
    step();
    check("hold.rdata", bus.ReadData, 32'h11BB33DD);

    // Read and write the same word in one cycle
    bus.Address = 32'h14; bus.WriteData = 32'hCAFEF00D; bus.ByteEnable = 4'hF;
    bus.WriteEnable = 1'b1; bus.ReadEnable = 1'b1;
    step();
    check("rw.old", bus.ReadData, 32'h0);
    check("rw.valid", 32'(bus.ReadValid), 32'd1);
    check("rw.dato2", bus.DATO2, 32'hCAFEF00D);
    idle();
    rd("rw.new", 32'h14, 32'hCAFEF00D);
    wr(32'h3C, 32'h0F0F0F0F, 4'hF);
    rd("w15", 32'h3C, 32'h0F0F0F0F);
    wr(32'h1C, 32'h55, 4'hF);
    check("tap.result", bus.RESULTADO, 32'h55);

    // CPU write to IN_SLOT stalls the peripheral word
    bus.Address = 32'h04; bus.WriteData = 32'h5; bus.ByteEnable = 4'hF; bus.WriteEnable = 1'b1;
    bus.MouseData = 32'h7; bus.MouseValid = 1'b1;
    #1;
    check("hs.stall", 32'(bus.MouseReady), 32'd0);
    step();
    bus.WriteEnable = 1'b0; bus.ByteEnable = 4'h0; bus.ReadEnable = 1'b1;
    #1;
    check("hs.ready", 32'(bus.MouseReady), 32'd1);
    step();
    check("hs.cpuwin", bus.ReadData, 32'h5);
    idle();
    rd("hs.w1", 32'h04, 32'h7);
    rd("hs.stat1", 32'h40, 32'h1);

    // Overrun and status clear
    xfer(32'h9);
    xfer(32'hA);
    rd("ovr.stat3", 32'h40, 32'h3);
    rd("ovr.clr", 32'h40, 32'h0);
    xfer(32'h11);
    xfer(32'h22);
    bus.MouseData = 32'h33; bus.MouseValid = 1'b1;
    rd("race.stat", 32'h40, 32'h3);
    rd("race.after", 32'h40, 32'h1);
    rd("race.clr", 32'h40, 32'h0);
    rd("race.w1", 32'h04, 32'h33);

    // STAT is read-only and a write there is not an error
    wr(32'h40, 32'hFFFFFFFF, 4'hF);
    check("statwr.aerr", 32'(bus.AddrError), 32'd0);
    rd("statwr.stat", 32'h40, 32'h0);

    // Bad accesses
    rd("bad.pre", 32'h10, 32'h11BB33DD);
    bus.Address = 32'h06; bus.ReadEnable = 1'b1;
    step();
    check("bad.rd.aerr", 32'(bus.AddrError), 32'd1);
    check("bad.rd.valid", 32'(bus.ReadValid), 32'd1);
    check("bad.rd.data", bus.ReadData, 32'h0);
    idle();
    step();
    check("bad.rd.pulse", 32'(bus.AddrError), 32'd0);
    wr(32'h1000, 32'hDEADBEEF, 4'hF);
    check("bad.wr.aerr", 32'(bus.AddrError), 32'd1);
    step();
    check("bad.wr.pulse", 32'(bus.AddrError), 32'd0);
    bus.Address = 32'h44; bus.ReadEnable = 1'b1;
    step();
    check("bad.44.aerr", 32'(bus.AddrError), 32'd1);
    idle();
    rd("bad.w0", 32'h00, 32'h0);
    check("bad.dato1", bus.DATO1, 32'h11BB33DD);
    rd("bad.w15", 32'h3C, 32'h0F0F0F0F);

    // Reset during an in-flight read
    rd("mid.pre", 32'h1C, 32'h55);
    bus.Address = 32'h1C; bus.ReadEnable = 1'b1;
    #2;
    RST = 1'b1;
    #1;
    check("mid.rdata", bus.ReadData, 32'h0);
    check("mid.rvalid", 32'(bus.ReadValid), 32'd0);
    check("mid.result", bus.RESULTADO, 32'h0);
    check("mid.dato1", bus.DATO1, 32'h2);
    step();
    idle();
    RST = 1'b0;
    step();
    check("mid.novalid", 32'(bus.ReadValid), 32'd0);
    rd("mid.w7", 32'h1C, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_memory_mmio.md
Name: data_memory_mmio

Overview:
Parametrised word-addressed data memory for the calculator datapath. It adds memory-mapped peripheral input with a valid/ready handshake and byte-lane writes. It provides a 1-cycle registered read path, a sticky status register for new and overrun data, and continuous display taps. Sits between the core's load/store path, the mouse/keypad interface and the display driver.

Parameters:
DATA_W, 32, data word width; multiple of 8
DEPTH, 16, number of words in the array; minimum 8
IN_SLOT, 1, word index written by the peripheral channel
TAP0_SLOT, 4, word index driven on DATO1
TAP1_SLOT, 5, word index driven on DATO2
TAP2_SLOT, 7, word index driven on RESULTADO
IN_RST_VAL, 2, reset value of IN_SLOT
TAP0_RST_VAL, 2, reset value of TAP0_SLOT

Ports:
CLK  in  1  clock; all state on rising edge
RST  in  1  asynchronous, active-high reset
Address  in  32  byte address from core
WriteData  in  DATA_W  store data
ByteEnable  in  DATA_W/8  per-lane write enable
WriteEnable  in  1  store request, this cycle
ReadEnable  in  1  load request, this cycle
ReadData  out  DATA_W  registered load data
ReadValid  out  1  pulses with ReadData, 1 cycle after ReadEnable
AddrError  out  1  pulses 1 cycle after a bad access
MouseData  in  DATA_W  peripheral word
MouseValid  in  1  peripheral word offered
MouseReady  out  1  peripheral word may be accepted
DATO1, DATO2, RESULTADO  out  DATA_W each  continuous views of the tap slots

Behaviour:
- Reset: one clock CLK; RST asynchronous, active-high. Effects:
  - all words become 0, except IN_SLOT=IN_RST_VAL and TAP0_SLOT=TAP0_RST_VAL;
  - ReadData=0, ReadValid=0, AddrError=0, status=0, MouseReady=1 after release.
  - An in-flight read is discarded; no ReadValid follows a reset.
- Address map: word i at byte address 4*i for i<DEPTH. The status register STAT sits at 4*DEPTH.
  - STAT bit0=NEW, bit1=OVR, other bits read 0.
- Bad access: Address[1:0]!=0, or Address>4*DEPTH.
  - Write is dropped; a read returns 0 with ReadValid=1.
  - AddrError=1 for exactly one cycle, registered.
- Writes: on the edge where WriteEnable=1, each lane with ByteEnable[k]=1 updates byte k of the addressed word. Writes to STAT are ignored and raise no error.
- Reads: ReadEnable at edge N gives ReadData/ReadValid valid after edge N, held until the next read. ReadValid is high one cycle only.
  - A read and a write to the same word in the same cycle return the old value.
  - When ReadEnable=0, ReadData holds its last value.
- Peripheral handshake:
  - MouseReady = !(WriteEnable && Address==4*IN_SLOT); the CPU write wins and the peripheral word stalls.
  - A transfer occurs on an edge with MouseValid && MouseReady. It writes the full word to IN_SLOT and sets NEW.
  - If NEW was already 1, OVR is also set.
- Status clear: a valid read of STAT returns pre-edge NEW/OVR and clears both at the same edge. A transfer in that same edge wins: NEW=1, OVR is cleared.
- Taps: DATO1/DATO2/RESULTADO show array contents combinationally. A write is visible after its edge. Tap slots may coincide with IN_SLOT.
- Simultaneous ReadEnable and WriteEnable to different words are both serviced.

Decomposition:
- Package data_memory_pkg holds:
  - STAT bit positions (STAT_NEW=0, STAT_OVR=1);
  - the function for word index and address-valid decode;
  - the byte-lane count macro/constant.
- Sub-module dm_word_array: DEPTH x DATA_W storage with byte-enable write port, registered read port, peripheral write port and reset values.
- Top level keeps decode, the status register, the handshake and the taps.

Test Plan:
- Reset release -> word1 reads 2, word4 reads 2, DATO1=2, others 0. ReadValid one cycle after ReadEnable; MouseReady=1.
- Write 0xAABBCCDD to 0x10 with ByteEnable=4'b0101 over 0x11223344 -> read returns 0x11BB33DD after 1 cycle; DATO1 matches.
- MouseValid with 0x7 while CPU writes 0x5 to 0x04 -> MouseReady=0, word1=0x5. Next cycle the transfer is accepted, word1=0x7, STAT=0x1.
- Second transfer 0x9 before STAT read -> STAT=0x3. Reading STAT returns 0x3 and the next STAT read returns 0x0; a read coinciding with a transfer returns 0x3, then STAT=0x1.
- Read 0x06 and write 0x1000 -> AddrError pulses once per access, ReadData=0, array unchanged.
- Assert RST mid-read with ReadEnable at 0x1C -> outputs zero immediately, no ReadValid after release, word7=0.
